// File: rtl/plb_dac_sample_sched_if.sv
// plb_dac_sample_sched_if - sample write port into the DAC playout scheduler.
// The PLB slave logic is the master (drives valid/data); the scheduler is the slave.
interface plb_dac_sample_sched_if #(
  parameter int DATA_W = 10
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/plb_dac_sample_sched.sv
// plb_dac_sample_sched - sample-playout scheduler for the 10-bit parallel DAC.
// Buffers two's complement samples in a 2**ADDR_W deep FIFO and paces them out to
// the DAC at a programmable rate, sequencing power-down, wake-up and drain.
// Build option: define DAC_SCHED_LOOP_EN to enable looped playback via cfg_loop;
// without it cfg_loop is ignored and playback is pure FIFO.
//
// state | meaning
// OFF   | DAC powered down, data parked at midscale, output format may change
// WAKE  | power-down released, waiting WAKE_CYCLES before the first sample
// RUN   | playing at the programmed rate; empty FIFO at a tick raises underrun
// DRAIN | playing out stored words, returns to OFF at the first empty tick
module plb_dac_sample_sched #(
  parameter int   DATA_W      = 10,
  parameter int   ADDR_W      = 4,
  parameter int   RATE_W      = 16,
  parameter int   WAKE_CYCLES = 64,
  parameter logic PIN_MODE    = 1'b0,
  parameter logic CLK_MODE    = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 cfg_enable,
  input  logic [RATE_W-1:0]    cfg_rate_div,
  input  logic                 cfg_format,
  input  logic                 cfg_loop,
  plb_dac_sample_sched_if.slave wr,
  output logic [ADDR_W:0]      fifo_level,
  output logic                 underrun,
  input  logic                 clr_underrun,
  output logic [1:0]           state,
  output logic [DATA_W-1:0]    dac_data,
  output logic                 dac_clk,
  output logic                 dac_pwrdn,
  output logic                 dac_format,
  output logic                 dac_pinmd,
  output logic                 dac_clkmd
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {S_OFF = 2'd0, S_WAKE = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3} state_t;

  state_t             r_state, w_state_next;
  logic [WAKE_W-1:0]  r_wake_cnt;
  logic [RATE_W-1:0]  r_div, r_period, w_rate_p;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_next, w_play_addr;
  logic [ADDR_W:0]    r_level;
  logic [DATA_W-1:0]  r_dac_data, w_rd_word;
  logic               r_format, r_underrun;
  logic               w_active, w_tick, w_empty, w_full, w_loop;
  logic               w_push, w_pop, w_play, w_set_underrun;

  function automatic logic [DATA_W-1:0] f_midscale(input logic fmt);
    return fmt ? {DATA_W{1'b0}} : {1'b1, {(DATA_W-1){1'b0}}};
  endfunction

  // Input samples are two's complement; offset binary is the same code with MSB flipped.
  function automatic logic [DATA_W-1:0] f_convert(input logic [DATA_W-1:0] s, input logic fmt);
    return fmt ? s : {~s[DATA_W-1], s[DATA_W-2:0]};
  endfunction

  assign w_rate_p = (cfg_rate_div == '0) ? RATE_W'(1) : cfg_rate_div;
  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_tick   = w_active && (r_div == r_period);
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == (ADDR_W+1)'(DEPTH));

`ifdef DAC_SCHED_LOOP_EN
  logic [ADDR_W-1:0] r_play_ptr, w_play_off;

  // Looping replays the stored words in place, so the FIFO is frozen while it lasts.
  assign w_loop      = cfg_loop && (r_state == S_RUN);
  assign w_play_addr = w_loop ? r_play_ptr : r_rd_ptr;
  assign w_play_off  = r_play_ptr - r_rd_ptr;

  // Play pointer walks the stored words while looping, otherwise shadows the read pointer.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_play_ptr <= '0;
    end else if (!w_loop) begin
      r_play_ptr <= w_rd_ptr_next;
    end else if (w_play) begin
      r_play_ptr <= (({1'b0, w_play_off} + (ADDR_W+1)'(1)) == r_level) ? r_rd_ptr
                                                                        : r_play_ptr + ADDR_W'(1);
    end
  end
`else
  logic w_unused_loop;

  assign w_loop        = 1'b0;
  assign w_play_addr   = r_rd_ptr;
  assign w_unused_loop = cfg_loop;
`endif

  assign wr.wr_ready    = !w_full && !w_loop;
  assign w_push         = wr.wr_valid && !w_full && !w_loop;
  assign w_play         = w_tick && !w_empty;
  assign w_pop          = w_play && !w_loop;
  assign w_rd_word      = r_mem[w_play_addr];
  assign w_rd_ptr_next  = r_rd_ptr + ADDR_W'(w_pop);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= S_OFF;
    else          r_state <= w_state_next;
  end

  // Next-state decode; enable during DRAIN resumes RUN without a gap.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_OFF:   if (cfg_enable) w_state_next = S_WAKE;
      S_WAKE:  if (!cfg_enable) w_state_next = S_OFF;
               else if (r_wake_cnt == '0) w_state_next = S_RUN;
      S_RUN:   if (!cfg_enable) w_state_next = S_DRAIN;
      S_DRAIN: if (cfg_enable) w_state_next = S_RUN;
               else if (w_tick && w_empty) w_state_next = S_OFF;
      default: w_state_next = S_OFF;
    endcase
  end

  // Output decode: sample clock low for the first half of each period so data moves while low.
  always_comb begin
    dac_pwrdn      = (r_state == S_OFF);
    dac_clk        = w_active && (r_div > (r_period >> 1));
    w_set_underrun = w_tick && w_empty && (r_state == S_RUN);
  end

  // Wake-up timer: preloaded while OFF, counts down to zero in WAKE.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_wake_cnt <= '0;
    end else if (r_state == S_OFF) begin
      r_wake_cnt <= WAKE_W'(WAKE_CYCLES - 1);
    end else if ((r_state == S_WAKE) && (r_wake_cnt != '0)) begin
      r_wake_cnt <= r_wake_cnt - WAKE_W'(1);
    end
  end

  // Sample-period divider; the period is only re-sampled at a wrap so a period is never cut short.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_div    <= '0;
      r_period <= RATE_W'(1);
    end else if (!w_active || w_tick) begin
      r_div    <= '0;
      r_period <= w_rate_p;
    end else begin
      r_div    <= r_div + RATE_W'(1);
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr.wr_data;
  end

  // FIFO pointers and level.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      r_rd_ptr <= w_rd_ptr_next;
      if (w_push && !w_pop)      r_level <= r_level + (ADDR_W+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (ADDR_W+1)'(1);
    end
  end

  // DAC data, latched format and sticky underrun.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_format   <= 1'b0;
      r_dac_data <= f_midscale(1'b0);
      r_underrun <= 1'b0;
    end else begin
      if (r_state == S_OFF) begin
        r_format   <= cfg_format;
        r_dac_data <= f_midscale(cfg_format);
      end else if (w_state_next == S_OFF) begin
        r_dac_data <= f_midscale(r_format);
      end else if (w_play) begin
        r_dac_data <= f_convert(w_rd_word, r_format);
      end
      if (w_set_underrun)    r_underrun <= 1'b1;
      else if (clr_underrun) r_underrun <= 1'b0;
    end
  end

  assign fifo_level = r_level;
  assign underrun   = r_underrun;
  assign state      = r_state;
  assign dac_data   = r_dac_data;
  assign dac_format = r_format;
  assign dac_pinmd  = PIN_MODE;
  assign dac_clkmd  = CLK_MODE;
endmodule
